// File: rtl/y_event_tally_pkg.sv
// Shared definitions for the Y-vector event tally: FSM states, channel indices
// and the set of decoder codes that the upstream abc->Y decoder may legally emit.
package y_event_tally_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_DUMP = 1'b1
  } state_e;

  localparam int CH_Y1   = 0;
  localparam int CH_Y2   = 1;
  localparam int CH_Y3   = 2;
  localparam int CH_Y4   = 3;
  localparam int CH_ZERO = 4;
  localparam int NCH     = 5;

  localparam logic [2:0] IDX_LAST = 3'(CH_ZERO);

  localparam logic [3:0] Y_NONE = 4'b0000;
  localparam logic [3:0] Y_1    = 4'b0001;
  localparam logic [3:0] Y_2    = 4'b0010;
  localparam logic [3:0] Y_3    = 4'b0100;
  localparam logic [3:0] Y_12   = 4'b0011;

  function automatic logic y_is_legal(input logic [3:0] y);
    return (y == Y_NONE) || (y == Y_1) || (y == Y_2) || (y == Y_3) || (y == Y_12);
  endfunction

endpackage

// File: rtl/y_event_tally_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  // Count register: reset and clear dominate, increment stops at full scale.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != {W{1'b1}})) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/y_event_tally.sv
// Tallies decoded Y samples per output line plus an all-zero tally, flags
// illegal codes, and on request streams the five tallies out and clears.
module y_event_tally
  import y_event_tally_pkg::*;
#(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    in_y,
  input  logic          dump_req,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [2:0]    out_idx,
  output logic [CW-1:0] out_cnt,
  output logic          out_last,
  output logic          busy,
  output logic          err_illegal
);

  state_e           state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [2:0]       out_idx_q, out_idx_d;
  logic             err_q, err_d;
  logic             accept;
  logic             clr;
  logic [NCH-1:0]   inc;
  logic [CW-1:0]    cnt [NCH];

  assign in_ready = (state_q == ST_IDLE);
  assign accept   = in_valid & in_ready;

  // Per-channel increment strobes; the zero channel counts the decoder default path.
  always_comb begin
    inc          = '0;
    inc[CH_Y1]   = accept & in_y[CH_Y1];
    inc[CH_Y2]   = accept & in_y[CH_Y2];
    inc[CH_Y3]   = accept & in_y[CH_Y3];
    inc[CH_Y4]   = accept & in_y[CH_Y4];
    inc[CH_ZERO] = accept & (in_y == Y_NONE);
  end

  for (genvar g = 0; g < NCH; g++) begin : g_cnt
    sat_counter #(.W(CW)) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .inc   (inc[g]),
      .q     (cnt[g])
    );
  end

  // Next-state logic: enter DUMP on request, walk the word index, clear after the last word.
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_idx_d   = out_idx_q;
    clr         = 1'b0;
    err_d       = err_q | (accept & ~y_is_legal(in_y));
    case (state_q)
      ST_IDLE: begin
        if (dump_req) begin
          state_d     = ST_DUMP;
          out_valid_d = 1'b1;
          out_idx_d   = '0;
        end
      end
      ST_DUMP: begin
        if (out_valid_q && out_ready) begin
          if (out_idx_q == IDX_LAST) begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
            out_idx_d   = '0;
            clr         = 1'b1;
            err_d       = 1'b0;
          end else begin
            out_idx_d = out_idx_q + 3'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and readout registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
      err_q       <= err_d;
    end
  end

  // Output word mux; counters are frozen during DUMP so the selected value is a stable snapshot.
  always_comb begin
    out_cnt = '0;
    if (out_valid_q) begin
      for (int i = 0; i < NCH; i++) begin
        if (out_idx_q == 3'(i)) out_cnt = cnt[i];
      end
    end
  end

  assign out_valid   = out_valid_q;
  assign out_idx     = out_idx_q;
  assign out_last    = out_valid_q & (out_idx_q == IDX_LAST);
  assign busy        = (state_q == ST_DUMP);
  assign err_illegal = err_q;

endmodule

// File: tb/tb_y_event_tally.sv
// Bench for y_event_tally: two instances (CW=8 and CW=4) share one stimulus stream
// and are compared against a counting model with per-width saturation.
module tb_y_event_tally;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] in_y = 4'b0;
  logic       dump_req = 1'b0;
  logic       out_ready = 1'b1;

  logic       a_in_ready, a_out_valid, a_out_last, a_busy, a_err;
  logic [2:0] a_out_idx;
  logic [7:0] a_out_cnt;
  logic       b_in_ready, b_out_valid, b_out_last, b_busy, b_err;
  logic [2:0] b_out_idx;
  logic [3:0] b_out_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int m8 [5];
  int m4 [5];
  bit m_err;

  always #5 clk = ~clk;

  y_event_tally #(.CW(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready), .in_y(in_y),
    .dump_req(dump_req), .out_valid(a_out_valid), .out_ready(out_ready), .out_idx(a_out_idx),
    .out_cnt(a_out_cnt), .out_last(a_out_last), .busy(a_busy), .err_illegal(a_err)
  );

  y_event_tally #(.CW(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready), .in_y(in_y),
    .dump_req(dump_req), .out_valid(b_out_valid), .out_ready(out_ready), .out_idx(b_out_idx),
    .out_cnt(b_out_cnt), .out_last(b_out_last), .busy(b_busy), .err_illegal(b_err)
  );

  function automatic bit legal(input logic [3:0] y);
    case (y)
      4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b0011: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic void model_accept(input logic [3:0] y);
    for (int i = 0; i < 5; i++) begin
      bit hit;
      hit = (i < 4) ? y[i] : (y == 4'b0000);
      if (hit) begin
        m8[i] = (m8[i] < 255) ? m8[i] + 1 : 255;
        m4[i] = (m4[i] < 15) ? m4[i] + 1 : 15;
      end
    end
    if (!legal(y)) m_err = 1'b1;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 5; i++) begin
      m8[i] = 0;
      m4[i] = 0;
    end
    m_err = 1'b0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] y);
    in_valid = 1'b1;
    in_y     = y;
    n_checks++;
    if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL send_in_ready: got %b/%b want 1", a_in_ready, b_in_ready);
    end
    tick();
    model_accept(y);
    in_valid = 1'b0;
  endtask

  // Requests a dump (optionally with a same-cycle sample) and reads all five words.
  task automatic dump_check(input string name, input bit with_s, input logic [3:0] y,
                            input int stall_idx, input int stall_n, input bit rnd);
    int k, held, budget;
    bit rdy;
    dump_req  = 1'b1;
    in_valid  = with_s;
    in_y      = y;
    out_ready = 1'b1;
    tick();
    dump_req = 1'b0;
    in_valid = 1'b0;
    if (with_s) model_accept(y);
    k = 0; held = 0; budget = 0;
    while (k < 5 && budget < 200) begin
      n_checks++;
      if (a_out_valid !== 1'b1 || a_out_idx !== 3'(k) || a_out_cnt !== 8'(m8[k]) ||
          b_out_cnt !== 4'(m4[k]) || b_out_idx !== 3'(k) || a_out_last !== (k == 4) ||
          a_busy !== 1'b1 || a_in_ready !== 1'b0 || a_err !== m_err) begin
        n_fail++;
        $display("FAIL %s word%0d: valid=%b idx=%0d cnt=%0d/%0d last=%b busy=%b rdy=%b err=%b; want idx=%0d cnt=%0d/%0d last=%b err=%b",
                 name, k, a_out_valid, a_out_idx, a_out_cnt, b_out_cnt, a_out_last, a_busy,
                 a_in_ready, a_err, k, m8[k], m4[k], (k == 4), m_err);
      end
      if (rnd) rdy = 1'($urandom_range(0, 1));
      else     rdy = !(k == stall_idx && held < stall_n);
      if (!rdy) held++;
      out_ready = rdy;
      dump_req  = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      in_valid  = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      in_y      = 4'($urandom);
      tick();
      budget++;
      if (rdy) k++;
    end
    dump_req  = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n_checks++;
    if (budget >= 200) begin
      n_fail++;
      $display("FAIL %s timeout: reached word %0d want 5", name, k);
    end
    n_checks++;
    if (a_out_valid !== 1'b0 || a_busy !== 1'b0 || a_in_ready !== 1'b1 || a_err !== 1'b0 ||
        a_out_last !== 1'b0 || b_out_valid !== 1'b0 || b_err !== 1'b0) begin
      n_fail++;
      $display("FAIL %s end: valid=%b busy=%b rdy=%b err=%b last=%b want 0 0 1 0 0",
               name, a_out_valid, a_busy, a_in_ready, a_err, a_out_last);
    end
    model_clear();
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_y     = 4'b0001;
    repeat (2) tick();
    n_checks++;
    if (a_out_valid !== 1'b0 || a_out_idx !== 3'd0 || a_out_cnt !== 8'd0 || a_out_last !== 1'b0 ||
        a_busy !== 1'b0 || a_err !== 1'b0 || b_out_valid !== 1'b0 || b_out_cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: valid=%b idx=%0d cnt=%0d last=%b busy=%b err=%b want all 0",
               a_out_valid, a_out_idx, a_out_cnt, a_out_last, a_busy, a_err);
    end
    rst_n    = 1'b1;
    in_valid = 1'b0;
    tick();
    n_checks++;
    if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1 || a_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: in_ready=%b/%b busy=%b want 1/1 0", a_in_ready, b_in_ready, a_busy);
    end
    model_clear();
    dump_check("reset_zero", 1'b0, 4'b0, -1, 0, 1'b0);
  endtask

  task automatic test_tally();
    send(4'b0001); send(4'b0010); send(4'b0100); send(4'b0011); send(4'b0000); send(4'b0000);
    n_checks++;
    if (a_err !== 1'b0) begin
      n_fail++;
      $display("FAIL tally_err: got %b want 0", a_err);
    end
    dump_check("tally", 1'b0, 4'b0, -1, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    send(4'b0001); send(4'b0010); send(4'b0100); send(4'b0011); send(4'b0000); send(4'b0000);
    dump_check("backpressure", 1'b0, 4'b0, 2, 3, 1'b0);
  endtask

  task automatic test_saturation();
    repeat (20) send(4'b0001);
    dump_check("sat20", 1'b0, 4'b0, -1, 0, 1'b0);
    repeat (270) send(4'b0000);
    dump_check("sat270", 1'b0, 4'b0, -1, 0, 1'b0);
  endtask

  task automatic test_illegal_overlap();
    send(4'b1001);
    n_checks++;
    if (a_err !== 1'b1 || b_err !== 1'b1) begin
      n_fail++;
      $display("FAIL illegal_flag: got %b/%b want 1", a_err, b_err);
    end
    dump_check("overlap", 1'b1, 4'b0100, -1, 0, 1'b0);
    dump_check("after_clear", 1'b0, 4'b0, -1, 0, 1'b0);
  endtask

  task automatic test_reset_mid_dump();
    send(4'b0001); send(4'b0010);
    dump_req  = 1'b1;
    out_ready = 1'b1;
    tick();
    dump_req = 1'b0;
    tick();
    n_checks++;
    if (a_out_valid !== 1'b1 || a_out_idx !== 3'd1) begin
      n_fail++;
      $display("FAIL middump_word1: valid=%b idx=%0d want 1 1", a_out_valid, a_out_idx);
    end
    rst_n = 1'b0;
    tick();
    n_checks++;
    if (a_out_valid !== 1'b0 || a_busy !== 1'b0 || a_in_ready !== 1'b1 || a_out_last !== 1'b0 ||
        a_out_idx !== 3'd0 || b_out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL middump_abort: valid=%b busy=%b rdy=%b idx=%0d want 0 0 1 0",
               a_out_valid, a_busy, a_in_ready, a_out_idx);
    end
    rst_n = 1'b1;
    model_clear();
    dump_check("post_reset", 1'b0, 4'b0, -1, 0, 1'b0);
  endtask

  task automatic test_random();
    logic [3:0] legal_set [5];
    logic [3:0] y;
    int n;
    legal_set[0] = 4'b0000; legal_set[1] = 4'b0001; legal_set[2] = 4'b0010;
    legal_set[3] = 4'b0100; legal_set[4] = 4'b0011;
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(10, 60);
      for (int s = 0; s < n; s++) begin
        if ($urandom_range(0, 3) == 0) begin
          in_valid = 1'b0;
          tick();
        end else begin
          if (r >= 3 && $urandom_range(0, 7) == 0) y = 4'($urandom);
          else y = legal_set[$urandom_range(0, 4)];
          send(y);
        end
      end
      n_checks++;
      if (a_err !== m_err || b_err !== m_err) begin
        n_fail++;
        $display("FAIL random_err r%0d: got %b/%b want %b", r, a_err, b_err, m_err);
      end
      y = legal_set[$urandom_range(0, 4)];
      dump_check("random", 1'($urandom_range(0, 1)), y, -1, 0, 1'b1);
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_tally();
    test_backpressure();
    test_saturation();
    test_illegal_overlap();
    test_reset_mid_dump();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
